hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
- Hazard detection and operand-forwarding controller for the 5-stage pipelined MIPS core.
- Keeps its own shadow pipeline of destination-register info for the E, M and W stages.
- From that state it generates:
  - the 2-bit select codes for the execute-stage forwarding mux3 instances (srca / srcb);
  - the 1-bit decode-stage branch-compare forwards;
  - load-use and branch stalls, pipeline flushes;
  - a saturating stall performance counter.

Parameters:
- REGW, 5, register-index width.
- CNTW, 32, stall counter width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_d  in  1  D-stage holds a real instruction.
- rs_d  in  REGW  D-stage source register A.
- rt_d  in  REGW  D-stage source register B.
- writereg_d  in  REGW  D-stage destination register (after regdst resolution).
- regwrite_d  in  1  D-stage instruction writes the register file.
- memtoreg_d  in  1  D-stage instruction is a load.
- branch_d  in  1  D-stage instruction is a beq/bne.
- pcsrc_d  in  1  branch resolved taken in D.
- forward_ae  out  2  srcA select: 00 regfile, 01 W result, 10 M aluout.
- forward_be  out  2  srcB select, same encoding.
- forward_ad  out  1  D compare A takes M aluout.
- forward_bd  out  1  D compare B takes M aluout.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold the F/D register.
- flush_d  out  1  clear the F/D register.
- flush_e  out  1  clear the D/E register.
- stall_cnt  out  CNTW  number of stall cycles since reset.

Behaviour:
- Shadow stage record: {vld, rs, rt, writereg, regwrite, memtoreg}, held for E, M and W.
- Reset (rst_n low, asynchronous): all records zeroed; stall_cnt = 0.
  - Consequences: forward_* = 0, and stall_f/stall_d/flush_e = 0 regardless of D inputs.
  - flush_d = pcsrc_d.
- Hazard terms, all combinational from D inputs and stage registers. "Match X" means X != 0 and X == rs_d or X == rt_d.
  - D qualifier: every D-side term requires valid_d = 1.
  - lwstall = E.vld & E.memtoreg & match(E.writereg).
  - brstall = branch_d & ((E.vld & E.regwrite & match(E.writereg)) | (M.vld & M.memtoreg & match(M.writereg))).
  - stall = lwstall | brstall.
  - stall_f = stall_d = flush_e = stall.
  - flush_d = pcsrc_d & ~stall.
- Forwarding to E (srcA; srcB identical using E.rt):
  - E.rs == 0: 00; register 0 is never forwarded.
  - Else if M.vld & M.regwrite & M.writereg == E.rs: 10 (M has priority).
  - Else if W.vld & W.regwrite & W.writereg == E.rs: 01.
  - Else: 00.
  - Code 11 is never produced.
- forward_ad = (rs_d != 0) & M.vld & M.regwrite & (M.writereg == rs_d). forward_bd uses rt_d the same way.
- Clock edge update:
  - W <= M; M <= E.
  - E <= bubble (all zero) if stall, else D fields with vld = valid_d.
  - A flushed D (flush_d) enters E next cycle only through valid_d, which the core drives to 0.
- stall_cnt increments on every clock edge where stall = 1; saturates at all-ones and never wraps.
- Latency: all outputs are combinational from the current stage registers and D inputs; the shadow pipeline advances exactly one stage per clock.
- Boundary cases:
  - Load in E writing $0: no stall.
  - lwstall and brstall both true: one stall cycle is counted once.
  - M and W both match: 10.
  - Reset asserted mid-stall: outputs drop asynchronously; the counter clears.

Decomposition:
- Shared package (hazard_pkg):
  - forward codes FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - stage record typedef (or a packed-field constant list);
  - REG_ZERO constant.
- Sub-module: fwd_sel. Combinational per-operand select generator, instantiated twice for srcA/srcB and reused for the D-stage compare bits.

Test Plan:
- Reset check: hold rst_n = 0 with valid_d = 1, rs_d = 5, branch_d = 1 -> all stall/forward outputs 0, stall_cnt = 0.
- Back-to-back ALU ops: add $3 enters D, then add $4, $3, $3 -> next cycle forward_ae = forward_be = 10. With one unrelated op in between -> 01.
- Load-use: lw $2 in E; D has rs_d = 2 -> stall_f = stall_d = flush_e = 1 for exactly one cycle. Next cycle forward_ae = 01; stall_cnt = 1.
- Branch after ALU: add $7 in E; D beq rs_d = 7 -> 1-cycle stall, then forward_ad = 1. With lw $7 instead -> 2 stall cycles; stall_cnt += 2.
- Register zero: lw $0 in E, D uses rs_d = 0 -> no stall; forward_ae stays 00.
- Taken branch and saturation: pcsrc_d = 1 with no stall -> flush_d = 1; with stall = 1 -> flush_d = 0. Force stall_cnt to all-ones via CNTW = 4 -> stays 15 under continued stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared forwarding codes and constants for the hazard/forward unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  typedef logic [1:0] fwd_t;

  localparam fwd_t FWD_RF  = 2'b00;
  localparam fwd_t FWD_WB  = 2'b01;
  localparam fwd_t FWD_MEM = 2'b10;

  localparam int unsigned REG_ZERO = 0;

  // Number of operands resolved by the select generators: srcA/srcB in E, A/B in D.
  localparam int unsigned NUM_OPERANDS = 4;

endpackage

`default_nettype wire

// File: rtl/hazard_fwd_unit_if.sv
// ============================================================================
// Module : hazard_fwd_unit_if
// Brief  : Decode-stage request and hazard/forward response bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface hazard_fwd_unit_if #(
  parameter int REGW = 5,
  parameter int CNTW = 32
);
  import hazard_pkg::*;

  logic            valid_d;
  logic [REGW-1:0] rs_d;
  logic [REGW-1:0] rt_d;
  logic [REGW-1:0] writereg_d;
  logic            regwrite_d;
  logic            memtoreg_d;
  logic            branch_d;
  logic            pcsrc_d;

  fwd_t            forward_ae;
  fwd_t            forward_be;
  logic            forward_ad;
  logic            forward_bd;
  logic            stall_f;
  logic            stall_d;
  logic            flush_d;
  logic            flush_e;
  logic [CNTW-1:0] stall_cnt;

  modport master (
    output valid_d, rs_d, rt_d, writereg_d, regwrite_d, memtoreg_d, branch_d, pcsrc_d,
    input  forward_ae, forward_be, forward_ad, forward_bd,
    input  stall_f, stall_d, flush_d, flush_e, stall_cnt
  );

  modport slave (
    input  valid_d, rs_d, rt_d, writereg_d, regwrite_d, memtoreg_d, branch_d, pcsrc_d,
    output forward_ae, forward_be, forward_ad, forward_bd,
    output stall_f, stall_d, flush_d, flush_e, stall_cnt
  );

endinterface

`default_nettype wire

// File: rtl/hazard_fwd_unit_fwd_sel.sv
// ============================================================================
// Module : fwd_sel
// Brief  : Per-operand forward select; M result wins over W, $0 never forwarded.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] src,
  input  logic            m_en,
  input  logic [REGW-1:0] m_reg,
  input  logic            w_en,
  input  logic [REGW-1:0] w_reg,
  output fwd_t            sel
);

  always_comb begin
    sel = FWD_RF;
    if (src != REGW'(REG_ZERO)) begin
      if (m_en && (m_reg == src)) begin
        sel = FWD_MEM;
      end else if (w_en && (w_reg == src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
// ============================================================================
// Module : hazard_fwd_unit
// Brief  : Shadow E/M/W pipeline driving forward selects, stalls and flushes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REGW = 5,
  parameter int CNTW = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_fwd_unit_if.slave   bus
);

  typedef struct packed {
    logic            vld;
    logic [REGW-1:0] rs;
    logic [REGW-1:0] rt;
    logic [REGW-1:0] writereg;
    logic            regwrite;
    logic            memtoreg;
  } stage_t;

  stage_t          e_q, m_q, w_q, e_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

  logic lwstall, brstall, stall;
  logic m_fwd_en, w_fwd_en;

  function automatic logic src_match(input logic [REGW-1:0] x,
                                     input logic [REGW-1:0] a,
                                     input logic [REGW-1:0] b);
    return (x != REGW'(REG_ZERO)) && ((x == a) || (x == b));
  endfunction

  always_comb begin
    lwstall = bus.valid_d & e_q.vld & e_q.memtoreg & src_match(e_q.writereg, bus.rs_d, bus.rt_d);
    brstall = bus.valid_d & bus.branch_d &
              ((e_q.vld & e_q.regwrite & src_match(e_q.writereg, bus.rs_d, bus.rt_d)) |
               (m_q.vld & m_q.memtoreg & src_match(m_q.writereg, bus.rs_d, bus.rt_d)));
    stall   = lwstall | brstall;
  end

  assign m_fwd_en = m_q.vld & m_q.regwrite;
  assign w_fwd_en = w_q.vld & w_q.regwrite;

  // Operands 0/1 are the E sources; 2/3 are the D compare sources, which only see M.
  logic [REGW-1:0] op_src [NUM_OPERANDS];
  fwd_t            op_sel [NUM_OPERANDS];

  assign op_src[0] = e_q.rs;
  assign op_src[1] = e_q.rt;
  assign op_src[2] = bus.rs_d;
  assign op_src[3] = bus.rt_d;

  for (genvar i = 0; i < NUM_OPERANDS; i++) begin : g_fwd_sel
    fwd_sel #(.REGW(REGW)) u_fwd_sel (
      .src   (op_src[i]),
      .m_en  (m_fwd_en),
      .m_reg (m_q.writereg),
      .w_en  ((i < 2) ? w_fwd_en : 1'b0),
      .w_reg (w_q.writereg),
      .sel   (op_sel[i])
    );
  end

  assign bus.forward_ae = op_sel[0];
  assign bus.forward_be = op_sel[1];
  assign bus.forward_ad = (op_sel[2] == FWD_MEM);
  assign bus.forward_bd = (op_sel[3] == FWD_MEM);
  assign bus.stall_f    = stall;
  assign bus.stall_d    = stall;
  assign bus.flush_e    = stall;
  assign bus.flush_d    = bus.pcsrc_d & ~stall;
  assign bus.stall_cnt  = stall_cnt_q;

  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.vld      = bus.valid_d;
      e_d.rs       = bus.rs_d;
      e_d.rt       = bus.rt_d;
      e_d.writereg = bus.writereg_d;
      e_d.regwrite = bus.regwrite_d;
      e_d.memtoreg = bus.memtoreg_d;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      stall_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= e_q;
      w_q         <= m_q;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Source fields in M/W and the load flag in W are carried for the record only.
  logic unused_stage_bits;
  assign unused_stage_bits = ^{m_q.rs, m_q.rt, w_q.rs, w_q.rt, w_q.memtoreg};

endmodule

`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
// ============================================================================
// Module : tb_hazard_fwd_unit
// Brief  : Directed + random bench against an instruction-level hazard model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_fwd_unit;

  localparam int REGW    = 5;
  localparam int CNTW    = 4;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  hazard_fwd_unit_if #(.REGW(REGW), .CNTW(CNTW)) bus ();

  hazard_fwd_unit #(.REGW(REGW), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Instruction-level view of the pipeline: index 0 = E, 1 = M, 2 = W.
  typedef struct {
    bit vld;
    int rs;
    int rt;
    int wr;
    bit rw;
    bit ld;
  } instr_t;

  instr_t pipe [3];
  instr_t dcur;
  bit     br_cur;
  bit     pc_cur;
  int     cnt_model;
  int     checks = 0;
  int     errors = 0;

  function automatic bit reads(int x);
    return (x != 0) && ((x == dcur.rs) || (x == dcur.rt));
  endfunction

  function automatic bit exp_stall();
    bit load_use, branch_wait;
    load_use    = dcur.vld && pipe[0].vld && pipe[0].ld && reads(pipe[0].wr);
    branch_wait = dcur.vld && br_cur &&
                  ((pipe[0].vld && pipe[0].rw && reads(pipe[0].wr)) ||
                   (pipe[1].vld && pipe[1].ld && reads(pipe[1].wr)));
    return load_use || branch_wait;
  endfunction

  // Youngest older producer wins; code 2 = M result, 1 = W result.
  function automatic int exp_fwd(int src, int oldest);
    if (src == 0) return 0;
    for (int j = 1; j <= oldest; j++) begin
      if (pipe[j].vld && pipe[j].rw && pipe[j].wr == src) return (j == 1) ? 2 : 1;
    end
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit s;
    s = exp_stall();
    check({tag, "/forward_ae"}, 32'(bus.forward_ae), exp_fwd(pipe[0].rs, 2));
    check({tag, "/forward_be"}, 32'(bus.forward_be), exp_fwd(pipe[0].rt, 2));
    check({tag, "/forward_ad"}, 32'(bus.forward_ad), 32'(exp_fwd(dcur.rs, 1) == 2));
    check({tag, "/forward_bd"}, 32'(bus.forward_bd), 32'(exp_fwd(dcur.rt, 1) == 2));
    check({tag, "/stall_f"},    32'(bus.stall_f),    32'(s));
    check({tag, "/stall_d"},    32'(bus.stall_d),    32'(s));
    check({tag, "/flush_e"},    32'(bus.flush_e),    32'(s));
    check({tag, "/flush_d"},    32'(bus.flush_d),    32'(pc_cur && !s));
    check({tag, "/stall_cnt"},  32'(bus.stall_cnt),  cnt_model);
  endtask

  task automatic model_reset();
    for (int j = 0; j < 3; j++) pipe[j] = '{default: 0};
    cnt_model = 0;
  endtask

  task automatic model_advance();
    bit s;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s = exp_stall();
    if (s && cnt_model < CNT_MAX) cnt_model++;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (s) pipe[0] = '{default: 0};
    else   pipe[0] = dcur;
  endtask

  task automatic drive(input bit v, input int rs, input int rt, input int wr,
                       input bit rw, input bit ld, input bit b, input bit p);
    dcur           = '{v, rs, rt, wr, rw, ld};
    br_cur         = b;
    pc_cur         = p;
    bus.valid_d    = v;
    bus.rs_d       = REGW'(rs);
    bus.rt_d       = REGW'(rt);
    bus.writereg_d = REGW'(wr);
    bus.regwrite_d = rw;
    bus.memtoreg_d = ld;
    bus.branch_d   = b;
    bus.pcsrc_d    = p;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Entered #1 after a rising edge; checks at the falling edge, then advances.
  task automatic cycle(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    model_advance();
    #1;
  endtask

  initial begin
    model_reset();
    drive(1, 5, 0, 0, 0, 0, 1, 0);
    #1;
    cycle("reset0");
    check("reset_stall_f", 32'(bus.stall_f), 0);
    cycle("reset1");
    check("reset_cnt", 32'(bus.stall_cnt), 0);
    rst_n = 1'b1;

    // add $3 ; add $4,$3,$3 -> M forward
    drive(1, 1, 2, 3, 1, 0, 0, 0); cycle("alu_a");
    drive(1, 3, 3, 4, 1, 0, 0, 0); cycle("alu_b");
    nop(); cycle("alu_fwd_mem");
    check("alu_fwd_mem_ae", 32'(bus.forward_ae), 0);
    nop(); cycle("alu_drain");

    // add $3 ; unrelated ; add $4,$3,$3 -> W forward
    drive(1, 1, 2, 3, 1, 0, 0, 0); cycle("alu_gap_a");
    drive(1, 1, 1, 9, 1, 0, 0, 0); cycle("alu_gap_mid");
    drive(1, 3, 3, 4, 1, 0, 0, 0); cycle("alu_gap_b");
    @(negedge clk);
    check("alu_gap_fwd_ae", 32'(bus.forward_ae), 32'(2'b01));
    check("alu_gap_fwd_be", 32'(bus.forward_be), 32'(2'b01));
    @(posedge clk); model_advance(); #1;

    // lw $2 ; use $2 held while stalled
    drive(1, 1, 0, 2, 1, 1, 0, 0); cycle("lw_a");
    drive(1, 2, 0, 5, 1, 0, 0, 0);
    @(negedge clk);
    check("lw_use_stall", 32'(bus.stall_f), 1);
    @(posedge clk); model_advance(); #1;
    cycle("lw_use_release");
    nop(); cycle("lw_use_fwd");
    nop(); cycle("lw_drain");

    // add $7 ; beq $7 -> one stall, then D-compare forward
    drive(1, 1, 1, 7, 1, 0, 0, 0); cycle("br_alu_a");
    drive(1, 7, 0, 0, 0, 0, 1, 0); cycle("br_alu_stall");
    @(negedge clk);
    check("br_alu_fwd_ad", 32'(bus.forward_ad), 1);
    @(posedge clk); model_advance(); #1;
    nop(); cycle("br_alu_drain");

    // lw $7 ; beq $7 -> two stalls
    drive(1, 1, 0, 7, 1, 1, 0, 0); cycle("br_lw_a");
    drive(1, 7, 0, 0, 0, 0, 1, 0);
    cycle("br_lw_s1"); cycle("br_lw_s2"); cycle("br_lw_go");
    nop(); cycle("br_lw_drain");

    // lw $0 ; use $0 -> never a hazard
    drive(1, 1, 0, 0, 1, 1, 0, 0); cycle("zero_lw");
    drive(1, 0, 0, 6, 1, 0, 0, 0); cycle("zero_use");
    nop(); cycle("zero_e");

    // Taken branch with and without a stall
    drive(1, 1, 1, 0, 0, 0, 1, 1); cycle("pcsrc_free");
    drive(1, 1, 0, 6, 1, 1, 0, 0); cycle("pcsrc_lw");
    drive(1, 6, 0, 0, 0, 0, 1, 1); cycle("pcsrc_stalled");
    nop(); cycle("pcsrc_drain");

    // Drive the 4-bit counter into saturation
    for (int k = 0; k < 20; k++) begin
      drive(1, 1, 0, 5, 1, 1, 0, 0); cycle("sat_lw");
      drive(1, 5, 5, 8, 1, 0, 0, 0); cycle("sat_use");
    end
    check("sat_cnt", 32'(bus.stall_cnt), CNT_MAX);
    cycle("sat_hold");

    // Asynchronous reset in the middle of a stall
    drive(1, 1, 0, 5, 1, 1, 0, 0); cycle("arst_lw");
    drive(1, 5, 0, 8, 1, 0, 1, 1);
    @(negedge clk);
    check_all("arst_pre");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst_in");
    check("arst_stall_f", 32'(bus.stall_f), 0);
    @(posedge clk); model_advance(); #1;
    rst_n = 1'b1;

    // Random traffic on a small register set to force collisions
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
